cmp_16b_sweep: RTL and testbench
================================

CMP_16B_SWEEP -- requirements
Module: cmp_16b_sweep

Interface
REQ-001 Parameter A_MAX, default 16'hFFFF: last value of operand a in the sweep, inclusive.
REQ-002 Parameter B_MAX, default 16'hFFFF: last value of operand b in the sweep, inclusive.
REQ-003 Parameter SETTLE_CYC, default 2, legal range 1..255: cycles each operand pair is held before the flags are sampled.
REQ-004 clk  input  1: single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 start  input  1: sweep request, sampled only in IDLE and DONE.
REQ-007 a_is_equal  input  1: comparator equal flag.
REQ-008 a_is_greater  input  1: comparator greater flag.
REQ-009 a_is_smaller  input  1: comparator smaller flag.
REQ-010 a  output  16: operand a, driven to the comparator.
REQ-011 b  output  16: operand b, driven to the comparator.
REQ-012 busy  output  1: high while in SETTLE or CHECK.
REQ-013 done  output  1: high while in DONE.
REQ-014 pass  output  1: equals done AND (err_cnt == 0).
REQ-015 err_cnt  output  16: count of mismatching pairs; saturates at 16'hFFFF.
REQ-016 first_err_a  output  16: value of a at the first mismatch.
REQ-017 first_err_b  output  16: value of b at the first mismatch.

Function
REQ-018 The FSM shall have exactly four states: IDLE, SETTLE, CHECK, DONE.
REQ-019 On start=1 in IDLE or DONE, the block shall on the next edge: set a=0, b=0, clear err_cnt, clear first_err_a/b, clear the settle counter, and enter SETTLE.
REQ-020 SETTLE shall last exactly SETTLE_CYC cycles and then go to CHECK; a and b shall be stable throughout.
REQ-021 CHECK shall last 1 cycle; expected flags are {eq,gt,lt} = {a==b, a>b, a<b}, unsigned compare of the registered a and b.
REQ-022 Mismatch: the sampled {a_is_equal,a_is_greater,a_is_smaller} differs from the expected value in any bit; this includes zero-hot and multi-hot flag patterns.
REQ-023 On a mismatch, err_cnt shall increment by 1 unless it is already 16'hFFFF.
REQ-024 When err_cnt is 0 on a mismatch, first_err_a/b shall capture a/b; later mismatches shall leave first_err_a/b unchanged.
REQ-025 Advance on leaving CHECK:
- if b != B_MAX: b <= b+1;
- else if a != A_MAX: b <= 0, a <= a+1;
- else: enter DONE with a and b unchanged.
- Otherwise the next state is SETTLE.
REQ-026 Every pair shall occupy SETTLE_CYC+1 cycles; done shall rise (A_MAX+1)*(B_MAX+1)*(SETTLE_CYC+1) cycles after the start edge.
REQ-027 start shall be ignored while busy=1.
REQ-028 DONE shall hold done, pass, err_cnt, first_err_a/b, a and b until start or reset.
REQ-029 A_MAX=B_MAX=0 shall give a one-pair sweep; A_MAX=B_MAX=16'hFFFF shall cover all 2^32 pairs, with no counter wrap before DONE.

Reset
REQ-030 rst_n=0 shall immediately force: state IDLE, a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, first_err_a=0, first_err_b=0, settle counter 0.
REQ-031 Reset in mid-sweep shall abandon the sweep; after release the block shall stay in IDLE until start.

Configuration
REQ-032 Macro CMP_SWEEP_STOP_ON_ERR_EN shall control early stop on mismatch.
- Defined: the first mismatch in CHECK shall enter DONE directly, with err_cnt=1 and a/b held at the failing pair.
- Undefined: the sweep shall always run to (A_MAX,B_MAX) and count every mismatch.

Verification
REQ-033 Golden comparator, A_MAX=3, B_MAX=3, SETTLE_CYC=2, start pulse -> done rises 48 cycles later, pass=1, err_cnt=0, a=3, b=3.
REQ-034 Flags forced 3'b000, A_MAX=B_MAX=1, macro undefined -> err_cnt=4, first_err_a=0, first_err_b=0, pass=0.
REQ-035 Comparator with gt/lt swapped, A_MAX=B_MAX=3, macro undefined -> err_cnt=12, first_err_a=0, first_err_b=1; same setup with macro defined -> done with err_cnt=1, a=0, b=1.
REQ-036 rst_n pulsed low at a=2, b=1 -> all outputs 0 asynchronously; start after release -> sweep restarts at a=0, b=0.
REQ-037 start held high during the sweep -> no restart; start in DONE -> err_cnt cleared and a fresh sweep runs.
REQ-038 Flags forced 3'b000, A_MAX=B_MAX=16'hFFFF, macro undefined -> err_cnt saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/cmp_16b_sweep.sv
// -----------------------------------------------------------------------------
// cmp_16b_sweep
//
// Exhaustive sweep tester for an external 16-bit magnitude comparator. The
// block walks every operand pair (a, b) from (0, 0) up to (A_MAX, B_MAX),
// b varying fastest. Each pair is held for SETTLE_CYC cycles so the
// comparator can settle. The flags are then checked for one cycle against
// the unsigned compare of the registered operands. Mismatches are counted,
// saturating at 16'hFFFF, and the first failing pair is recorded.
//
// Parameters
//   A_MAX      : last value of operand a (inclusive)
//   B_MAX      : last value of operand b (inclusive)
//   SETTLE_CYC : cycles each pair is held before sampling (1..255)
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   sweep request, honoured only in IDLE and DONE
//   a_is_equal   in   comparator equal flag
//   a_is_greater in   comparator greater flag
//   a_is_smaller in   comparator smaller flag
//   a, b         out  operands driven to the comparator
//   busy         out  high while settling or checking
//   done         out  high while the finished result is held
//   pass         out  done with no mismatches
//   err_cnt      out  saturating mismatch count
//   first_err_a  out  operand a of the first mismatching pair
//   first_err_b  out  operand b of the first mismatching pair
//
// Build option
//   CMP_SWEEP_STOP_ON_ERR_EN : when defined, the first mismatch ends the
//   sweep immediately, with the failing pair left on a/b. When undefined,
//   the sweep always runs to (A_MAX, B_MAX).
// -----------------------------------------------------------------------------
module cmp_16b_sweep #(
  parameter logic [15:0] A_MAX      = 16'hFFFF,
  parameter logic [15:0] B_MAX      = 16'hFFFF,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        a_is_equal,
  input  logic        a_is_greater,
  input  logic        a_is_smaller,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic [15:0] first_err_a,
  output logic [15:0] first_err_b
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  // The settle counter runs 0 .. SETTLE_CYC-1, so SETTLE lasts exactly
  // SETTLE_CYC cycles.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

`ifdef CMP_SWEEP_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  state_t      state;
  state_t      state_next;
  logic [7:0]  settle_cnt;
  logic [2:0]  flags_expected;
  logic [2:0]  flags_observed;
  logic        mismatch;
  logic        launch;
  logic        last_pair;
  logic        settle_end;

  // The reference is taken from the registered operands, so it is exactly
  // the value the comparator has been looking at during SETTLE.
  assign flags_expected = {a == b, a > b, a < b};
  assign flags_observed = {a_is_equal, a_is_greater, a_is_smaller};
  // A full-vector compare also catches zero-hot and multi-hot patterns.
  assign mismatch       = (state == CHECK) && (flags_observed != flags_expected);
  assign launch         = start && ((state == IDLE) || (state == DONE));
  assign last_pair      = (a == A_MAX) && (b == B_MAX);
  assign settle_end     = (state == SETTLE) && (settle_cnt == SETTLE_LAST);

  // Status outputs are decoded from the state, so reset clears them
  // immediately.
  assign busy = (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == 16'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. start is ignored while busy because SETTLE and CHECK
  // never look at it.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) state_next = SETTLE;
      end
      SETTLE: begin
        if (settle_end) state_next = CHECK;
      end
      CHECK: begin
        if (last_pair || (STOP_ON_ERR && mismatch)) begin
          state_next = DONE;
        end else begin
          state_next = SETTLE;
        end
      end
      DONE: begin
        if (start) state_next = SETTLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand, settle counter and error bookkeeping registers.
  // In DONE nothing below is written, so the result holds until start or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a           <= 16'd0;
      b           <= 16'd0;
      settle_cnt  <= 8'd0;
      err_cnt     <= 16'd0;
      first_err_a <= 16'd0;
      first_err_b <= 16'd0;
    end else if (launch) begin
      a           <= 16'd0;
      b           <= 16'd0;
      settle_cnt  <= 8'd0;
      err_cnt     <= 16'd0;
      first_err_a <= 16'd0;
      first_err_b <= 16'd0;
    end else if (state == SETTLE) begin
      // The counter is cleared on its way out, so the next pair's SETTLE
      // starts at zero.
      settle_cnt <= settle_end ? 8'd0 : settle_cnt + 8'd1;
    end else if (state == CHECK) begin
      if (mismatch) begin
        if (err_cnt != 16'hFFFF) begin
          err_cnt <= err_cnt + 16'd1;
        end
        if (err_cnt == 16'd0) begin
          first_err_a <= a;
          first_err_b <= b;
        end
      end
      // With early stop, a failing pair stays on a/b. On the last pair,
      // both operands stay put as the sweep ends.
      if (!(STOP_ON_ERR && mismatch)) begin
        if (b != B_MAX) begin
          b <= b + 16'd1;
        end else if (a != A_MAX) begin
          b <= 16'd0;
          a <= a + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_16b_sweep.sv
// -----------------------------------------------------------------------------
// tb_cmp_16b_sweep
//
// Bench for cmp_16b_sweep with a 4x4 sweep (A_MAX = B_MAX = 3, SETTLE_CYC = 2).
// The bench plays the comparator. It can answer correctly, with all flags
// forced low, with gt/lt swapped, or with a random per-pair corruption mask.
// A sweep-level model predicts the counts, the first failing pair, the final
// operands and the cycle count to done.
// -----------------------------------------------------------------------------
module tb_cmp_16b_sweep;

  localparam int SC    = 2;
  localparam int A_TOP = 3;
  localparam int B_TOP = 3;

`ifdef CMP_SWEEP_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  localparam logic [1:0] M_GOLDEN = 2'd0;
  localparam logic [1:0] M_ZERO   = 2'd1;
  localparam logic [1:0] M_SWAP   = 2'd2;
  localparam logic [1:0] M_RANDOM = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        a_is_equal;
  logic        a_is_greater;
  logic        a_is_smaller;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_cnt;
  logic [15:0] first_err_a;
  logic [15:0] first_err_b;

  logic [1:0]  mode;
  logic [2:0]  mask_tab [16];
  logic [2:0]  flags;

  int compared   = 0;
  int mismatched = 0;

  cmp_16b_sweep #(
    .A_MAX     (16'(A_TOP)),
    .B_MAX     (16'(B_TOP)),
    .SETTLE_CYC(SC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a_is_equal  (a_is_equal),
    .a_is_greater(a_is_greater),
    .a_is_smaller(a_is_smaller),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_cnt     (err_cnt),
    .first_err_a (first_err_a),
    .first_err_b (first_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Correct comparator answer from the sign of the integer difference.
  function automatic logic [2:0] truthFlags(input int ai, input int bi);
    int diff;
    diff = ai - bi;
    return {diff == 0, diff > 0, diff < 0};
  endfunction

  // What the bench comparator reports for a pair in a given mode.
  function automatic logic [2:0] benchFlags(input int ai, input int bi,
                                            input logic [1:0] m,
                                            input logic [2:0] msk);
    logic [2:0] t;
    t = truthFlags(ai, bi);
    case (m)
      M_GOLDEN: return t;
      M_ZERO:   return 3'b000;
      M_SWAP:   return {t[2], t[0], t[1]};
      default:  return t ^ msk;
    endcase
  endfunction

  always_comb begin
    flags = benchFlags(int'(a), int'(b), mode, mask_tab[{a[1:0], b[1:0]}]);
  end
  assign a_is_equal   = flags[2];
  assign a_is_greater = flags[1];
  assign a_is_smaller = flags[0];

  // Sweep-level prediction: visit pairs in order and tally the faulty ones.
  task automatic predictSweep(input logic [1:0] m,
                              output int e_err, output int e_fa, output int e_fb,
                              output int e_a, output int e_b, output int e_cyc);
    bit stopped;
    e_err = 0; e_fa = 0; e_fb = 0; e_a = A_TOP; e_b = B_TOP; e_cyc = 0;
    stopped = 1'b0;
    for (int ai = 0; ai <= A_TOP; ai++) begin
      for (int bi = 0; bi <= B_TOP; bi++) begin
        if (!stopped) begin
          e_cyc += SC + 1;
          if (benchFlags(ai, bi, m, mask_tab[ai*4 + bi]) != truthFlags(ai, bi)) begin
            if (e_err == 0) begin
              e_fa = ai;
              e_fb = bi;
            end
            e_err++;
            if (STOP) begin
              stopped = 1'b1;
              e_a = ai;
              e_b = bi;
            end
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  // Launches a sweep and counts cycles after the start edge until done.
  // start stays high for 'hold' further cycles to show it is ignored while busy.
  task automatic applyStimulus(input logic [1:0] m, input int hold, output int cycles);
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    cycles = 0;
    while (!done && cycles < 400) begin
      if (cycles >= hold) start = 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
  endtask

  int cyc;
  int e_err, e_fa, e_fb, e_a, e_b, e_cyc;
  int steps;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = M_GOLDEN;
    for (int i = 0; i < 16; i++) mask_tab[i] = 3'b000;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_a", a, 0);
    checkOutput("rst_b", b, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_err", err_cnt, 0);
    checkOutput("rst_fea", first_err_a, 0);
    checkOutput("rst_feb", first_err_b, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_busy", busy, 0);

    // Golden comparator, with start held high for part of the sweep.
    applyStimulus(M_GOLDEN, 20, cyc);
    $display("[TB] golden sweep finished after %0d cycles", cyc);
    checkOutput("gold_cycles", cyc, 48);
    checkOutput("gold_done", done, 1);
    checkOutput("gold_pass", pass, 1);
    checkOutput("gold_err", err_cnt, 0);
    checkOutput("gold_a", a, 3);
    checkOutput("gold_b", b, 3);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("gold_hold_done", done, 1);
    checkOutput("gold_hold_a", a, 3);
    checkOutput("gold_hold_busy", busy, 0);

    // Flags forced low: every pair mismatches.
    applyStimulus(M_ZERO, 0, cyc);
    checkOutput("zero_cycles", cyc, STOP ? 3 : 48);
    checkOutput("zero_err", err_cnt, STOP ? 1 : 16);
    checkOutput("zero_fea", first_err_a, 0);
    checkOutput("zero_feb", first_err_b, 0);
    checkOutput("zero_pass", pass, 0);

    // Start in DONE clears the result and starts a fresh sweep.
    mode  = M_GOLDEN;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("restart_err", err_cnt, 0);
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_a", a, 0);
    checkOutput("restart_b", b, 0);
    steps = 0;
    while (!done && steps < 400) begin
      @(posedge clk); #1;
      steps++;
    end
    checkOutput("restart_pass", pass, 1);

    // Comparator with gt and lt swapped: every a != b pair mismatches.
    applyStimulus(M_SWAP, 0, cyc);
    checkOutput("swap_err", err_cnt, STOP ? 1 : 12);
    checkOutput("swap_fea", first_err_a, 0);
    checkOutput("swap_feb", first_err_b, 1);
    checkOutput("swap_a", a, STOP ? 0 : 3);
    checkOutput("swap_b", b, 1 + (STOP ? 0 : 2));
    checkOutput("swap_cycles", cyc, STOP ? 6 : 48);

    // Random corruption masks checked against the sweep model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        mask_tab[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      end
      predictSweep(M_RANDOM, e_err, e_fa, e_fb, e_a, e_b, e_cyc);
      applyStimulus(M_RANDOM, 0, cyc);
      checkOutput("rand_cycles", cyc, e_cyc);
      checkOutput("rand_err", err_cnt, e_err);
      checkOutput("rand_fea", first_err_a, e_fa);
      checkOutput("rand_feb", first_err_b, e_fb);
      checkOutput("rand_a", a, e_a);
      checkOutput("rand_b", b, e_b);
      checkOutput("rand_pass", pass, (e_err == 0) ? 1 : 0);
    end

    // Reset in mid-sweep at a=2, b=1.
    mode  = M_ZERO;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    steps = 0;
    while (!(a == 16'd2 && b == 16'd1) && steps < 400) begin
      @(posedge clk); #1;
      steps++;
    end
    checkOutput("midrst_reached", (a == 16'd2 && b == 16'd1) ? 1 : 0, STOP ? 0 : 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_a", a, 0);
    checkOutput("midrst_b", b, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_err", err_cnt, 0);
    checkOutput("midrst_fea", first_err_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midrst_idle_busy", busy, 0);
    checkOutput("midrst_idle_done", done, 0);
    mode  = M_GOLDEN;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("midrst_start_a", a, 0);
    checkOutput("midrst_start_b", b, 0);
    checkOutput("midrst_start_busy", busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
